// File: rtl/accel_frame_sender.sv
// accel_frame_sender: assembles 6-byte accelerometer frames into X/Y/Z samples,
// buffers them in a FIFO and streams them out with window marking. Clamp option: ACCEL_SAT_EN.
module accel_frame_sender #(
    parameter int DEPTH     = 8,
    parameter int WINDOW    = 100,
    parameter int SAT_LIMIT = 4095
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    input  logic                     byte_sync,
    input  logic                     out_ready,
    output logic                     start,
    output logic [15:0]              accel_x,
    output logic [15:0]              accel_y,
    output logic [15:0]              accel_z,
    output logic                     window_last,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               overflow_cnt,
    output logic [7:0]               resync_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WINDOW < 1 ||
        SAT_LIMIT < 1 || SAT_LIMIT > 32767) begin : g_param_check
        $error("accel_frame_sender: illegal parameter value");
    end

    typedef enum logic {WAIT_SYNC, COLLECT} asm_state_t;

    asm_state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] store_idx;
    logic [7:0] hold_q [5];
    logic       store;
    logic       frame_done;
    logic       resync;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        store      = 1'b0;
        frame_done = 1'b0;
        resync     = 1'b0;
        if (byte_valid) begin
            unique case (state_q)
                WAIT_SYNC: begin
                    if (byte_sync) begin
                        store   = 1'b1;
                        idx_d   = 3'd1;
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    if (byte_sync) begin
                        resync = 1'b1;
                        store  = 1'b1;
                        idx_d  = 3'd1;
                    end else if (idx_q == 3'd5) begin
                        frame_done = 1'b1;
                        idx_d      = 3'd0;
                        state_d    = WAIT_SYNC;
                    end else begin
                        store = 1'b1;
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign store_idx = byte_sync ? 3'd0 : idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_SYNC;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) hold_q[store_idx] <= byte_in;
    end

    // ZH goes straight from the bus into the write word, so no extra cycle
    logic [15:0] raw_x, raw_y, raw_z;
    logic [47:0] wr_data;

    assign raw_x = {hold_q[1], hold_q[0]};
    assign raw_y = {hold_q[3], hold_q[2]};
    assign raw_z = {byte_in, hold_q[4]};

`ifdef ACCEL_SAT_EN
    localparam logic signed [16:0] LIM_P = 17'(SAT_LIMIT);
    localparam logic signed [16:0] LIM_N = -LIM_P;

    function automatic logic [15:0] clamp(input logic [15:0] v);
        logic signed [16:0] s;
        s = {v[15], v};
        if (s > LIM_P) return LIM_P[15:0];
        if (s < LIM_N) return LIM_N[15:0];
        return v;
    endfunction

    assign wr_data = {clamp(raw_z), clamp(raw_y), clamp(raw_x)};
`else
    assign wr_data = {raw_z, raw_y, raw_x};
`endif

    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, full, push, drop;

    assign pop        = (count != '0) && out_ready;
    assign full       = (count == (AW + 1)'(DEPTH));
    assign push       = frame_done && (!full || pop);
    assign drop       = frame_done && full && !pop;
    assign fifo_level = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= '0;
            resync_cnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (drop && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
            if (resync && resync_cnt != 8'hFF) resync_cnt <= resync_cnt + 8'd1;
        end
    end

    logic [WW-1:0] win_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start       <= 1'b0;
            window_last <= 1'b0;
            win_cnt     <= '0;
            accel_x     <= '0;
            accel_y     <= '0;
            accel_z     <= '0;
        end else if (pop) begin
            start                       <= 1'b1;
            {accel_z, accel_y, accel_x} <= mem[rd_ptr];
            if (win_cnt == WW'(WINDOW - 1)) begin
                window_last <= 1'b1;
                win_cnt     <= '0;
            end else begin
                window_last <= 1'b0;
                win_cnt     <= win_cnt + 1'b1;
            end
        end else begin
            start       <= 1'b0;
            window_last <= 1'b0;
        end
    end
endmodule
